// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
// Module   : envelope_vca
// Brief    : Envelope-controlled amplifier; scales each wave sample by the
//            ADSR level with a one-bit-per-clock shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module envelope_vca #(
  parameter int WAVE_DEPTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SampleValid,
  input  logic [WAVE_DEPTH-1:0] Wave,
  input  logic [WAVE_DEPTH-1:0] Envolope,
  output logic                  Ready,
  output logic [WAVE_DEPTH-1:0] Out,
  output logic                  OutValid,
  output logic                  Overrun
);

  localparam int c_CNT_W = (WAVE_DEPTH > 1) ? $clog2(WAVE_DEPTH) : 1;
  localparam int c_ACC_W = 2 * WAVE_DEPTH;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WAVE_DEPTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [WAVE_DEPTH-1:0] r_w;
  logic [WAVE_DEPTH-1:0] r_e;
  logic [c_ACC_W-1:0]    r_acc;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [WAVE_DEPTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_overrun;
  logic [c_ACC_W-1:0]    w_addend;
  logic [c_ACC_W-1:0]    w_wave_ext;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (SampleValid) w_next_state = c_MUL;
      c_MUL:   if (r_cnt == c_LAST) w_next_state = c_DONE;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Ready = (r_state == c_IDLE);
  end

  assign w_wave_ext = {{WAVE_DEPTH{1'b0}}, r_w};
  assign w_addend   = w_wave_ext << r_cnt;

  // Adding W before the final shift makes full-scale envelope unity gain;
  // (2^N-1)^2 + (2^N-1) < 2^(2N), so the sum fits the accumulator width.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_w         <= '0;
      r_e         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (SampleValid && (r_state != c_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (SampleValid) begin
            r_w   <= Wave;
            r_e   <= Envolope;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        c_MUL: begin
          if (r_e[r_cnt]) begin
            r_acc <= r_acc + w_addend;
          end
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        c_DONE: begin
          r_out       <= WAVE_DEPTH'((r_acc + w_wave_ext) >> WAVE_DEPTH);
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Out      = r_out;
  assign OutValid = r_out_valid;
  assign Overrun  = r_overrun;

endmodule
`default_nettype wire
